fast_arc_detector: RTL and testbench
====================================

// Module: fast_arc_detector
// PURPOSE
//  Parametrised FAST segment test for one candidate pixel. Classifies the 16 Bresenham-circle
//  pixels as bright, dark or similar against centre +/- threshold, then detects a circular run
//  of ARC_LEN contiguous bright or dark points. Reports corner flag, polarity and arc start index.
//  Sits between the circle-window buffer and the non-max-suppression stage; fixed 4-cycle latency.
// PARAMETERS
//  PIX_W    8  pixel/threshold width in bits
//  ARC_LEN  9  required contiguous arc length, legal 1..16; elaboration error outside this range
// PORTS
//  clk        in   1         clock
//  rst        in   1         synchronous reset, active-high
//  ce         in   1         clock enable; 0 freezes every pipeline register
//  in_valid   in   1         candidate present on centre/circle/thr this cycle
//  centre     in   PIX_W     centre pixel intensity
//  circle     in   16*PIX_W  circle pixels, point i at [i*PIX_W +: PIX_W], i=0..15 clockwise
//  thr        in   PIX_W     threshold, sampled with the candidate
//  out_valid  out  1         result valid
//  corner     out  1         ARC_LEN-run found
//  polarity   out  1         1=bright, 0=dark; 0 when corner=0
//  arc_start  out  4         lowest start index of a qualifying run; 0 when corner=0
//  score      out  PIX_W+4   present only with FAST_SCORE_EN (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: out_valid, corner, polarity, arc_start, score and all internal stage valids = 0.
//    Reset mid-operation discards all in-flight candidates. out_valid is 0 from the first cycle after reset.
//  - Pipeline advances only when ce=1. Latency: 4 ce-cycles, in_valid to out_valid.
//    Throughput: one candidate per ce-cycle. No backpressure.
//  - S1 compare: uses (PIX_W+1)-bit arithmetic.
//    bright[i] = circle[i] > centre+thr. dark[i] = circle[i] < centre-thr.
//    Comparisons are strict. centre-thr < 0 means no dark point possible.
//    centre+thr > 2^PIX_W-1 means no bright point possible.
//  - S2 run detect: hit_b[s] = AND of bright[(s+k) mod 16] for k=0..ARC_LEN-1. hit_d is the same on dark.
//    The run may wrap from point 15 to point 0.
//  - S3 select: corner = |hit_b or |hit_d.
//    If both are set (only possible for ARC_LEN<=8), bright wins.
//    arc_start = lowest s with hit set for the chosen polarity. An all-ones vector gives arc_start=0.
//  - S4 register outputs. corner, polarity and arc_start are held at 0 when the stage valid is 0.
//  - in_valid=0 still flows a bubble; outputs are zero for bubbles.
// CONFIGURATION
//  FAST_SCORE_EN defined: adds the score output.
//    score = sum over i of the class margin for the chosen polarity:
//    bright: circle[i]-centre-thr; dark: centre-thr-circle[i].
//    Only points set in that class are summed. Result is unsigned and saturates at 2^(PIX_W+4)-1.
//    score=0 when corner=0. Same 4-cycle latency; the adder tree is split across S2/S3.
//  Not defined: no score port and no adder logic. All other behaviour is identical.
// STRUCTURE
//  Package fast_pkg: N_PTS=16, IDX_W=4, polarity localparams POL_DARK/POL_BRIGHT,
//  function circ_run(vec16, len) returning a 16-bit hit vector.
//  Sub-module fast_arc_run (16-bit class vector -> registered hit vector + any-hit).
//  It is instantiated twice, once for bright and once for dark. Compare, select, score and valid pipe stay in this module.
// TESTING  (PIX_W=8, ARC_LEN=9, thr=20 unless stated)
//  1 centre=100, pts0..8=130, rest=100 -> after 4 ce: out_valid=1 corner=1 polarity=1 arc_start=0; score=90 if FAST_SCORE_EN.
//  2 centre=100, pts12..15,0..4=60, rest=100 -> corner=1 polarity=0 arc_start=12 (wrap case).
//  3 centre=100, pts0..7=130, rest=100 -> corner=0 (8-run only).
//    Same test with pts0..8 at 120 (=c+t) -> corner=0 (strict compare).
//  4 Saturation: centre=250, all pts=255, thr=20 -> corner=0.
//    centre=5, all pts=0, thr=20 -> corner=0.
//    centre=5, all pts=255 -> corner=1 polarity=1 arc_start=0.
//  5 Back-to-back cases 1,2,3 with ce low for 2 cycles mid-stream -> outputs frozen during the stall; results appear in order.
//  6 rst asserted with 3 candidates in flight -> out_valid=0 on the next cycle; none of the 3 results ever appears.

Source files
------------

// File: rtl/fast_pkg.sv
// Shared constants and the circular-run helper for the FAST segment test.
package fast_pkg;

    localparam int unsigned N_PTS = 16;
    localparam int unsigned IDX_W = 4;

    localparam logic POL_DARK   = 1'b0;
    localparam logic POL_BRIGHT = 1'b1;

    // Bit s of the result is set when vec holds len ones starting at s, wrapping past point 15.
    function automatic logic [N_PTS-1:0] circ_run(input logic [N_PTS-1:0] vec,
                                                  input int unsigned len);
        logic [N_PTS-1:0] hit;
        logic [IDX_W-1:0] idx;
        for (int unsigned s = 0; s < N_PTS; s++) begin
            hit[s] = 1'b1;
            for (int unsigned k = 0; k < N_PTS; k++) begin
                idx = IDX_W'((s + k) % N_PTS);
                if (k < len) hit[s] = hit[s] & vec[idx];
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/fast_arc_run.sv
// Registered circular-run detector: one class vector in, hit vector and any-hit out.
module fast_arc_run
    import fast_pkg::*;
#(
    parameter int unsigned ARC_LEN = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic [N_PTS-1:0] vec,
    output logic [N_PTS-1:0] hit,
    output logic             any
);

    always_ff @(posedge clk) begin
        if (rst) begin
            hit <= '0;
        end else if (ce) begin
            hit <= circ_run(vec, ARC_LEN);
        end
    end

    assign any = |hit;

endmodule

// File: rtl/fast_arc_detector.sv
// FAST segment test for one candidate pixel, fixed 4 ce-cycle latency.
// Define FAST_SCORE_EN to add the corner score output and its adder tree.
module fast_arc_detector
    import fast_pkg::*;
#(
    parameter int unsigned PIX_W   = 8,
    parameter int unsigned ARC_LEN = 9
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ce,
    input  logic                   in_valid,
    input  logic [PIX_W-1:0]       centre,
    input  logic [N_PTS*PIX_W-1:0] circle,
    input  logic [PIX_W-1:0]       thr,
    output logic                   out_valid,
    output logic                   corner,
    output logic                   polarity,
    output logic [IDX_W-1:0]       arc_start
`ifdef FAST_SCORE_EN
    ,
    output logic [PIX_W+3:0]       score
`endif
);

    if (ARC_LEN < 1 || ARC_LEN > N_PTS) begin : g_bad_arc_len
        $error("fast_arc_detector: ARC_LEN must be in 1..16");
    end

    // ---------------- S1: classify ----------------
    logic [PIX_W:0]     hi, lo;
    logic               lo_ok;
    logic [N_PTS-1:0]   bright_d, dark_d, bright_q, dark_q;
    logic               v1, v2, v3;

    assign hi    = {1'b0, centre} + {1'b0, thr};
    assign lo    = {1'b0, centre} - {1'b0, thr};
    assign lo_ok = (centre >= thr);

    always_comb begin
        bright_d = '0;
        dark_d   = '0;
        for (int i = 0; i < N_PTS; i++) begin
            // hi above the pixel range makes every compare false, so no extra guard is needed
            bright_d[i] = {1'b0, circle[i*PIX_W +: PIX_W]} > hi;
            dark_d[i]   = lo_ok && ({1'b0, circle[i*PIX_W +: PIX_W]} < lo);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1       <= 1'b0;
            v2       <= 1'b0;
            v3       <= 1'b0;
            bright_q <= '0;
            dark_q   <= '0;
        end else if (ce) begin
            v1       <= in_valid;
            v2       <= v1;
            v3       <= v2;
            bright_q <= bright_d;
            dark_q   <= dark_d;
        end
    end

    // ---------------- S2: run detect ----------------
    logic [N_PTS-1:0] hit_b, hit_d;
    logic             any_b, any_d;

    fast_arc_run #(.ARC_LEN(ARC_LEN)) u_run_bright (
        .clk (clk),
        .rst (rst),
        .ce  (ce),
        .vec (bright_q),
        .hit (hit_b),
        .any (any_b)
    );

    fast_arc_run #(.ARC_LEN(ARC_LEN)) u_run_dark (
        .clk (clk),
        .rst (rst),
        .ce  (ce),
        .vec (dark_q),
        .hit (hit_d),
        .any (any_d)
    );

    // ---------------- S3: select ----------------
    logic [N_PTS-1:0] hit_sel;
    logic [IDX_W-1:0] start_d, start3;
    logic             corner3, pol3;

    assign hit_sel = any_b ? hit_b : hit_d;

    always_comb begin
        start_d = '0;
        for (int s = N_PTS - 1; s >= 0; s--) begin
            if (hit_sel[s]) start_d = IDX_W'(s);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            corner3 <= 1'b0;
            pol3    <= POL_DARK;
            start3  <= '0;
        end else if (ce) begin
            corner3 <= any_b | any_d;
            pol3    <= any_b ? POL_BRIGHT : POL_DARK;
            start3  <= start_d;
        end
    end

    // ---------------- S4: outputs ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            corner    <= 1'b0;
            polarity  <= 1'b0;
            arc_start <= '0;
        end else if (ce) begin
            out_valid <= v3;
            corner    <= v3 & corner3;
            polarity  <= v3 & corner3 & pol3;
            arc_start <= (v3 && corner3) ? start3 : '0;
        end
    end

`ifdef FAST_SCORE_EN
    // One extra bit over the score width so saturation can be detected after the final add.
    localparam int unsigned SUM_W = PIX_W + 5;

    logic [PIX_W-1:0] mb_d [N_PTS];
    logic [PIX_W-1:0] md_d [N_PTS];
    logic [PIX_W-1:0] mb_q [N_PTS];
    logic [PIX_W-1:0] md_q [N_PTS];
    logic [SUM_W-1:0] pb_d [2];
    logic [SUM_W-1:0] pd_d [2];
    logic [SUM_W-1:0] pb_q [2];
    logic [SUM_W-1:0] pd_q [2];
    logic [SUM_W-1:0] tot_sel;
    logic [PIX_W+3:0] score3;

    always_comb begin
        for (int i = 0; i < N_PTS; i++) begin
            mb_d[i] = bright_d[i] ? circle[i*PIX_W +: PIX_W] - hi[PIX_W-1:0] : '0;
            md_d[i] = dark_d[i] ? lo[PIX_W-1:0] - circle[i*PIX_W +: PIX_W] : '0;
        end
    end

    always_comb begin
        pb_d[0] = '0;
        pb_d[1] = '0;
        pd_d[0] = '0;
        pd_d[1] = '0;
        for (int i = 0; i < N_PTS / 2; i++) begin
            pb_d[0] = pb_d[0] + SUM_W'(mb_q[i]);
            pb_d[1] = pb_d[1] + SUM_W'(mb_q[i+N_PTS/2]);
            pd_d[0] = pd_d[0] + SUM_W'(md_q[i]);
            pd_d[1] = pd_d[1] + SUM_W'(md_q[i+N_PTS/2]);
        end
    end

    always_comb begin
        tot_sel = '0;
        if (any_b)      tot_sel = pb_q[0] + pb_q[1];
        else if (any_d) tot_sel = pd_q[0] + pd_q[1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_PTS; i++) begin
                mb_q[i] <= '0;
                md_q[i] <= '0;
            end
            pb_q[0] <= '0;
            pb_q[1] <= '0;
            pd_q[0] <= '0;
            pd_q[1] <= '0;
            score3  <= '0;
            score   <= '0;
        end else if (ce) begin
            for (int i = 0; i < N_PTS; i++) begin
                mb_q[i] <= mb_d[i];
                md_q[i] <= md_d[i];
            end
            pb_q[0] <= pb_d[0];
            pb_q[1] <= pb_d[1];
            pd_q[0] <= pd_d[0];
            pd_q[1] <= pd_d[1];
            score3  <= tot_sel[SUM_W-1] ? '1 : tot_sel[PIX_W+3:0];
            score   <= (v3 && corner3) ? score3 : '0;
        end
    end
`endif

endmodule

// File: tb/tb_fast_arc_detector.sv
// Self-checking bench for fast_arc_detector: directed cases, stall, reset flush and random traffic.
module tb_fast_arc_detector;

    localparam int PIX_W   = 8;
    localparam int ARC_LEN = 9;
    localparam int SC_W    = PIX_W + 4;
    localparam int OBS_W   = 1 + 1 + 1 + 4 + SC_W;

    logic                clk;
    logic                rst;
    logic                ce;
    logic                in_valid;
    logic [PIX_W-1:0]    centre;
    logic [16*PIX_W-1:0] circle;
    logic [PIX_W-1:0]    thr;
    logic                out_valid;
    logic                corner;
    logic                polarity;
    logic [3:0]          arc_start;
    logic [SC_W-1:0]     sc_obs;
`ifdef FAST_SCORE_EN
    logic [SC_W-1:0]     score;
    assign sc_obs = score;
`else
    assign sc_obs = '0;
`endif

    fast_arc_detector #(.PIX_W(PIX_W), .ARC_LEN(ARC_LEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .in_valid  (in_valid),
        .centre    (centre),
        .circle    (circle),
        .thr       (thr),
        .out_valid (out_valid),
        .corner    (corner),
        .polarity  (polarity),
        .arc_start (arc_start)
`ifdef FAST_SCORE_EN
        ,
        .score     (score)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [OBS_W-1:0] exp_obs;
    logic [OBS_W-1:0] exp_q[$];
    logic [OBS_W-1:0] obs;

    function automatic logic [OBS_W-1:0] pack(input logic v, input logic c, input logic p,
                                              input int s, input int sc);
        logic [SC_W-1:0] sc_f;
        sc_f = SC_W'(sc);
`ifndef FAST_SCORE_EN
        sc_f = '0;
`endif
        return {v, c, p, 4'(s), sc_f};
    endfunction

    always_comb obs = pack(out_valid, corner, polarity, int'(arc_start), int'(sc_obs));

    // Reference: classify each point with signed integers, then search runs directly.
    function automatic logic [OBS_W-1:0] ref_model(input logic [PIX_W-1:0] c,
                                                   input logic [16*PIX_W-1:0] circ,
                                                   input logic [PIX_W-1:0] t);
        bit b[16];
        bit d[16];
        int ci, ti, p, sum_b, sum_d, bs, ds;
        bit ok_b, ok_d;
        ci = int'(c);
        ti = int'(t);
        sum_b = 0;
        sum_d = 0;
        for (int i = 0; i < 16; i++) begin
            p = int'(circ[i*PIX_W +: PIX_W]);
            b[i] = p > ci + ti;
            d[i] = p < ci - ti;
            if (b[i]) sum_b += p - ci - ti;
            if (d[i]) sum_d += ci - ti - p;
        end
        bs = -1;
        ds = -1;
        for (int s = 15; s >= 0; s--) begin
            ok_b = 1;
            ok_d = 1;
            for (int k = 0; k < ARC_LEN; k++) begin
                ok_b &= b[(s + k) % 16];
                ok_d &= d[(s + k) % 16];
            end
            if (ok_b) bs = s;
            if (ok_d) ds = s;
        end
        if (sum_b > (1 << SC_W) - 1) sum_b = (1 << SC_W) - 1;
        if (sum_d > (1 << SC_W) - 1) sum_d = (1 << SC_W) - 1;
        if (bs >= 0) return pack(1, 1, 1, bs, sum_b);
        if (ds >= 0) return pack(1, 1, 0, ds, sum_d);
        return pack(1, 0, 0, 0, 0);
    endfunction

    function automatic logic [16*PIX_W-1:0] mk_circ(input int base, input int val,
                                                    input int s, input int l);
        logic [16*PIX_W-1:0] r;
        for (int i = 0; i < 16; i++) begin
            r[i*PIX_W +: PIX_W] = PIX_W'(((i - s + 16) % 16 < l) ? val : base);
        end
        return r;
    endfunction

    // One clock edge; the expected-output queue advances once per ce-cycle.
    task automatic step();
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            exp_obs = '0;
        end else if (ce) begin
            exp_q.push_back(in_valid ? ref_model(centre, circle, thr) : '0);
            if (exp_q.size() == 4) exp_obs = exp_q.pop_front();
            else exp_obs = '0;
        end
        #1;
    endtask

    task automatic gen_random();
        int s, l, v, ci, ti;
        bit pol;
        centre = PIX_W'($urandom);
        thr    = PIX_W'($urandom_range(0, 40));
        ci = int'(centre);
        ti = int'(thr);
        s   = $urandom_range(0, 15);
        l   = $urandom_range(0, 16);
        pol = 1'($urandom_range(0, 1));
        for (int i = 0; i < 16; i++) begin
            v = $urandom_range(0, 255);
            if ((i - s + 16) % 16 < l) begin
                v = pol ? ci + ti + $urandom_range(0, 60) : ci - ti - $urandom_range(0, 60);
            end
            if (v < 0) v = 0;
            if (v > 255) v = 255;
            circle[i*PIX_W +: PIX_W] = PIX_W'(v);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ce = 1'b1;
        in_valid = 1'b1;
        centre = 8'd5;
        thr = 8'd20;
        circle = mk_circ(255, 255, 0, 0);
        step();
        step();
        checks++;
        if (obs !== pack(0, 0, 0, 0, 0)) begin
            failures++;
            $display("FAIL reset_state got=%h want=%h", obs, pack(0, 0, 0, 0, 0));
        end
        rst = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic run_one(input string name, input logic [7:0] c, input logic [7:0] t,
                           input logic [16*PIX_W-1:0] circ, input logic [OBS_W-1:0] want);
        centre = c;
        thr = t;
        circle = circ;
        in_valid = 1'b1;
        ce = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL %s_early cyc=%0d out_valid=%b want=0", name, i, out_valid);
            end
            step();
        end
        checks++;
        if (obs !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, obs, want);
        end
    endtask

    task automatic test_directed();
        run_one("bright_arc", 100, 20, mk_circ(100, 130, 0, 9), pack(1, 1, 1, 0, 90));
        run_one("dark_wrap", 100, 20, mk_circ(100, 60, 12, 9), pack(1, 1, 0, 12, 180));
        run_one("run8_only", 100, 20, mk_circ(100, 130, 0, 8), pack(1, 0, 0, 0, 0));
        run_one("strict_eq", 100, 20, mk_circ(100, 120, 0, 9), pack(1, 0, 0, 0, 0));
        run_one("sat_high", 250, 20, mk_circ(255, 255, 0, 0), pack(1, 0, 0, 0, 0));
        run_one("sat_low", 5, 20, mk_circ(0, 0, 0, 0), pack(1, 0, 0, 0, 0));
        run_one("all_bright", 5, 20, mk_circ(255, 255, 0, 0), pack(1, 1, 1, 0, 3680));
    endtask

    task automatic test_back_to_back();
        logic [OBS_W-1:0] seen[$];
        logic [OBS_W-1:0] want[3];
        logic [OBS_W-1:0] held;
        bit ce_was;
        want[0] = pack(1, 1, 1, 0, 90);
        want[1] = pack(1, 1, 0, 12, 180);
        want[2] = pack(1, 0, 0, 0, 0);
        for (int cyc = 0; cyc < 12; cyc++) begin
            ce = (cyc == 4 || cyc == 5) ? 1'b0 : 1'b1;
            in_valid = (cyc < 3) ? 1'b1 : 1'b0;
            centre = 8'd100;
            thr = 8'd20;
            if (cyc == 0) circle = mk_circ(100, 130, 0, 9);
            else if (cyc == 1) circle = mk_circ(100, 60, 12, 9);
            else circle = mk_circ(100, 130, 0, 8);
            ce_was = ce;
            held = obs;
            step();
            checks++;
            if (obs !== exp_obs) begin
                failures++;
                $display("FAIL b2b_model cyc=%0d got=%h want=%h", cyc, obs, exp_obs);
            end
            if (!ce_was) begin
                checks++;
                if (obs !== held) begin
                    failures++;
                    $display("FAIL b2b_stall cyc=%0d got=%h want=%h", cyc, obs, held);
                end
            end else if (out_valid) begin
                seen.push_back(obs);
            end
        end
        checks++;
        if (seen.size() != 3) begin
            failures++;
            $display("FAIL b2b_count got=%0d want=3", seen.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (seen[i] !== want[i]) begin
                    failures++;
                    $display("FAIL b2b_order idx=%0d got=%h want=%h", i, seen[i], want[i]);
                end
            end
        end
        ce = 1'b1;
    endtask

    task automatic test_reset_flush();
        ce = 1'b1;
        in_valid = 1'b1;
        centre = 8'd100;
        thr = 8'd20;
        circle = mk_circ(100, 130, 0, 9);
        for (int i = 0; i < 3; i++) step();
        rst = 1'b1;
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_reset out_valid=%b want=0", out_valid);
        end
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b0 || corner !== 1'b0) begin
                failures++;
                $display("FAIL flush_leak cyc=%0d valid=%b corner=%b want=0", i, out_valid,
                         corner);
            end
        end
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 500; cyc++) begin
            ce = ($urandom_range(0, 3) != 0);
            in_valid = ($urandom_range(0, 3) != 0);
            gen_random();
            step();
            checks++;
            if (obs !== exp_obs) begin
                failures++;
                $display("FAIL random cyc=%0d got=%h want=%h", cyc, obs, exp_obs);
            end
        end
        ce = 1'b1;
        in_valid = 1'b0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            step();
            checks++;
            if (obs !== exp_obs) begin
                failures++;
                $display("FAIL random_drain cyc=%0d got=%h want=%h", cyc, obs, exp_obs);
            end
        end
    endtask

    initial begin
        exp_obs = '0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_flush();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
